// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 24-bit pipeline. Issues loads/stores over a
// req/ready handshake, stalls upstream while an access is in flight, and registers MEM/WB.
module mem_stage #(
  parameter int N       = 24,
  parameter int BW      = 64,
  parameter int WBW     = 60,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [BW-1:0]  exBuffer,
  input  logic [N-1:0]   memRData,
  input  logic           memReady,
  output logic           memReq,
  output logic           memWe,
  output logic [N-1:0]   memAddr,
  output logic [N-1:0]   memWData,
  output logic           stall,
  output logic           memErr,
  output logic [WBW-1:0] wbBuffer
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [N-1:0]   w_exRd3;
  logic [3:0]     w_exRc;
  logic           w_exRegWrite;
  logic           w_exMemToReg;
  logic           w_exMemWrite;
  logic [N-1:0]   w_exAlu;
  logic [3:0]     w_exOpCode;
  logic [1:0]     w_exOpType;
  logic           w_unusedFlags;
  logic           w_isMem;

  logic           r_memReq;
  logic           r_memWe;
  logic [N-1:0]   r_memAddr;
  logic [N-1:0]   r_memWData;
  logic           r_memErr;
  logic [WBW-1:0] r_wbBuffer;
  logic [CW-1:0]  r_count;
  logic [N-1:0]   r_holdData;

  logic [N-1:0]   r_ctlAlu;
  logic [3:0]     r_ctlRc;
  logic           r_ctlRegWrite;
  logic           r_ctlMemToReg;
  logic [3:0]     r_ctlOpCode;
  logic [1:0]     r_ctlOpType;

  logic           w_timeout;
  logic           w_complete;
  logic [N-1:0]   w_respData;
  logic [WBW-1:N] w_exWbCtl;
  logic [WBW-1:N] w_latchedWbCtl;

  logic           w_stall;
  logic           w_startAccess;
  logic           w_wbLoadEx;
  logic           w_wbLoadMem;
  logic           w_wbLoadHold;
  logic           w_holdCapture;

  assign w_exRd3       = exBuffer[23:0];
  assign w_exRc        = exBuffer[27:24];
  assign w_exRegWrite  = exBuffer[28];
  assign w_exMemToReg  = exBuffer[29];
  assign w_exMemWrite  = exBuffer[30];
  assign w_exAlu       = exBuffer[57:34];
  assign w_exOpCode    = exBuffer[61:58];
  assign w_exOpType    = exBuffer[63:62];
  // Branch/neg/zero flags are resolved in execute and are not carried forward.
  assign w_unusedFlags = ^exBuffer[33:31];

  assign w_isMem = w_exMemToReg | w_exMemWrite;

  assign w_exWbCtl      = {w_exOpType, w_exOpCode, w_exRegWrite, w_exMemToReg, w_exRc, w_exAlu};
  assign w_latchedWbCtl = {r_ctlOpType, r_ctlOpCode, r_ctlRegWrite, r_ctlMemToReg, r_ctlRc, r_ctlAlu};

  // A timeout completes the access like a ready strobe, but with no data.
  assign w_timeout  = (r_state == ST_WAIT) && !memReady && (r_count == TO_LAST);
  assign w_complete = (r_state == ST_WAIT) && (memReady || w_timeout);
  assign w_respData = (r_ctlMemToReg && memReady) ? memRData : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en && w_isMem) begin
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (w_complete) begin
          w_nextState = en ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        if (en) begin
          w_nextState = ST_IDLE;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stall       = 1'b0;
    w_startAccess = 1'b0;
    w_wbLoadEx    = 1'b0;
    w_wbLoadMem   = 1'b0;
    w_wbLoadHold  = 1'b0;
    w_holdCapture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          if (w_isMem) begin
            w_stall       = 1'b1;
            w_startAccess = 1'b1;
          end else begin
            w_wbLoadEx = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_stall = ~(w_complete & en);
        if (w_complete) begin
          w_wbLoadMem   = en;
          w_holdCapture = ~en;
        end
      end
      ST_DONE: begin
        w_stall      = ~en;
        w_wbLoadHold = en;
      end
      default: w_stall = 1'b0;
    endcase
  end

  // Stall is forced low while reset is asserted so upstream never sees a stale request.
  assign stall = rst & w_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWData <= '0;
    end else if (w_startAccess) begin
      r_memReq   <= 1'b1;
      r_memWe    <= w_exMemWrite;
      r_memAddr  <= w_exAlu;
      r_memWData <= w_exRd3;
    end else if (w_complete) begin
      r_memReq <= 1'b0;
      r_memWe  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ctlAlu      <= '0;
      r_ctlRc       <= '0;
      r_ctlRegWrite <= 1'b0;
      r_ctlMemToReg <= 1'b0;
      r_ctlOpCode   <= '0;
      r_ctlOpType   <= '0;
    end else if (w_startAccess) begin
      r_ctlAlu      <= w_exAlu;
      r_ctlRc       <= w_exRc;
      r_ctlRegWrite <= w_exRegWrite;
      r_ctlMemToReg <= w_exMemToReg;
      r_ctlOpCode   <= w_exOpCode;
      r_ctlOpType   <= w_exOpType;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (w_startAccess) begin
      r_count <= '0;
    end else if ((r_state == ST_WAIT) && !memReady && !w_timeout) begin
      r_count <= r_count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_memErr <= 1'b0;
    end else if (w_timeout) begin
      r_memErr <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_holdData <= '0;
    end else if (w_holdCapture) begin
      r_holdData <= w_respData;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wbBuffer <= '0;
    end else if (w_wbLoadEx) begin
      r_wbBuffer <= {w_exWbCtl, {N{1'b0}}};
    end else if (w_wbLoadMem) begin
      r_wbBuffer <= {w_latchedWbCtl, w_respData};
    end else if (w_wbLoadHold) begin
      r_wbBuffer <= {w_latchedWbCtl, r_holdData};
    end
  end

  assign memReq   = r_memReq;
  assign memWe    = r_memWe;
  assign memAddr  = r_memAddr;
  assign memWData = r_memWData;
  assign memErr   = r_memErr;
  assign wbBuffer = r_wbBuffer;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a field-level
// model of the EX/MEM -> MEM/WB transfer and the req/ready handshake.
module tb_mem_stage;

  localparam int N   = 24;
  localparam int BW  = 64;
  localparam int WBW = 60;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en = 1'b0;
  logic [BW-1:0]  exBuffer = '0;
  logic [N-1:0]   memRData = '0;
  logic           memReady = 1'b0;
  logic           memReq;
  logic           memWe;
  logic [N-1:0]   memAddr;
  logic [N-1:0]   memWData;
  logic           stall;
  logic           memErr;
  logic [WBW-1:0] wbBuffer;

  int checks = 0;
  int errors = 0;
  logic [WBW-1:0] modelWb = '0;

  always #5 clk = ~clk;

  mem_stage #(.N(N), .BW(BW), .WBW(WBW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .en(en), .exBuffer(exBuffer),
    .memRData(memRData), .memReady(memReady), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memWData(memWData), .stall(stall), .memErr(memErr),
    .wbBuffer(wbBuffer)
  );

  // MEM/WB image of an EX/MEM op: fields copied, flags dropped, readData supplied.
  function automatic logic [WBW-1:0] wbOf(input logic [BW-1:0] op, input logic [N-1:0] readData);
    return {op[63:62], op[61:58], op[28], op[29], op[27:24], op[57:34], readData};
  endfunction

  // kind: 0 non-memory, 1 load, 2 store, 3 bubble
  function automatic logic [BW-1:0] randOp(input int kind);
    logic [BW-1:0] op;
    op = {$urandom, $urandom};
    op[29] = (kind == 1);
    op[30] = (kind == 2);
    if (kind == 3) op = '0;
    return op;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic runPassOp(input logic [BW-1:0] op, input string tag);
    exBuffer = op;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_stall: got %0b expected 0", tag, stall);
    end
    step();
    modelWb = wbOf(op, '0);
    checks++;
    if (wbBuffer !== modelWb || memReq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_wb: got wb=%h req=%0b expected wb=%h req=0", tag, wbBuffer, memReq, modelWb);
    end
  endtask

  // Called at posedge+1; leaves op on exBuffer so the caller presents the next op at once.
  task automatic runMemOp(input logic [BW-1:0] op, input int d, input logic [N-1:0] rdata, input string tag);
    int stallCycles;
    stallCycles = 0;
    exBuffer = op;
    memReady = 1'b0;
    #1;
    if (stall === 1'b1) stallCycles++;
    step();
    checks++;
    if ({memReq, memWe, memAddr, memWData} !== {1'b1, op[30], op[57:34], op[23:0]}) begin
      errors++;
      $display("[TB] FAIL %s_issue: got req=%0b we=%0b addr=%h wdata=%h expected req=1 we=%0b addr=%h wdata=%h",
               tag, memReq, memWe, memAddr, memWData, op[30], op[57:34], op[23:0]);
    end
    for (int i = 0; i < d; i++) begin
      if (stall === 1'b1) stallCycles++;
      checks++;
      if (memReq !== 1'b1 || wbBuffer !== modelWb) begin
        errors++;
        $display("[TB] FAIL %s_wait: got req=%0b wb=%h expected req=1 wb=%h", tag, memReq, wbBuffer, modelWb);
      end
      step();
    end
    memReady = 1'b1;
    memRData = rdata;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_release: got stall=%0b expected 0", tag, stall);
    end
    step();
    memReady = 1'b0;
    memRData = N'($urandom);
    modelWb = wbOf(op, op[29] ? rdata : '0);
    checks++;
    if (stallCycles != d + 1) begin
      errors++;
      $display("[TB] FAIL %s_stallcount: got %0d expected %0d", tag, stallCycles, d + 1);
    end
    checks++;
    if (memReq !== 1'b0 || wbBuffer !== modelWb) begin
      errors++;
      $display("[TB] FAIL %s_complete: got req=%0b wb=%h expected req=0 wb=%h", tag, memReq, wbBuffer, modelWb);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b1;
    exBuffer = randOp(1);
    step();
    step();
    checks++;
    if ({memReq, memWe, memAddr, memWData, memErr, stall, wbBuffer} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got req=%0b we=%0b addr=%h wdata=%h err=%0b stall=%0b wb=%h expected all 0",
               memReq, memWe, memAddr, memWData, memErr, stall, wbBuffer);
    end
    exBuffer = '0;
    step();
    rst = 1'b1;
    modelWb = '0;
  endtask

  task automatic test_passthrough();
    logic [BW-1:0] op;
    op = '0;
    op[57:34] = 24'd4;
    op[27:24] = 4'd3;
    op[28] = 1'b1;
    op[61:58] = 4'd1;
    runPassOp(op, "pass");
    checks++;
    if ({wbBuffer[47:24], wbBuffer[51:48], wbBuffer[53], wbBuffer[57:54]} !== {24'd4, 4'd3, 1'b1, 4'd1}) begin
      errors++;
      $display("[TB] FAIL pass_fields: got wb=%h expected alu=4 rc=3 rw=1 opc=1", wbBuffer);
    end
  endtask

  task automatic test_load_wait3();
    logic [BW-1:0] op;
    op = '0;
    op[29] = 1'b1;
    op[57:34] = 24'h000010;
    runMemOp(op, 3, 24'hABCDEF, "load3");
    checks++;
    if (wbBuffer[23:0] !== 24'hABCDEF || wbBuffer[52] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL load3_data: got rdata=%h m2r=%0b expected rdata=abcdef m2r=1", wbBuffer[23:0], wbBuffer[52]);
    end
    runPassOp('0, "load3_bubble");
  endtask

  task automatic test_store_ready();
    logic [BW-1:0] op;
    op = '0;
    op[30] = 1'b1;
    op[57:34] = 24'h000020;
    op[23:0] = 24'h123456;
    runMemOp(op, 0, 24'h777777, "store0");
    checks++;
    if (wbBuffer[23:0] !== 24'h0) begin
      errors++;
      $display("[TB] FAIL store0_rdata: got %h expected 0", wbBuffer[23:0]);
    end
    runPassOp('0, "store0_bubble");
  endtask

  task automatic test_back_to_back();
    int kind;
    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 3);
      if (kind == 1 || kind == 2) begin
        runMemOp(randOp(kind), $urandom_range(0, 4), N'($urandom), "rand_mem");
      end else begin
        runPassOp(randOp(kind), "rand_pass");
      end
    end
    runPassOp('0, "rand_bubble");
  endtask

  task automatic test_en_done();
    logic [BW-1:0] op;
    logic [N-1:0] rd;
    op = randOp(1);
    rd = N'($urandom);
    exBuffer = op;
    step();
    en = 1'b0;
    memReady = 1'b1;
    memRData = rd;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL done_readystall: got %0b expected 1", stall);
    end
    step();
    memReady = 1'b0;
    memRData = N'($urandom);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (memReq !== 1'b0 || stall !== 1'b1 || wbBuffer !== modelWb) begin
        errors++;
        $display("[TB] FAIL done_hold: got req=%0b stall=%0b wb=%h expected req=0 stall=1 wb=%h", memReq, stall, wbBuffer, modelWb);
      end
      step();
    end
    en = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_release: got %0b expected 0", stall);
    end
    step();
    modelWb = wbOf(op, rd);
    checks++;
    if (wbBuffer !== modelWb) begin
      errors++;
      $display("[TB] FAIL done_wb: got %h expected %h", wbBuffer, modelWb);
    end
    // en=0 in IDLE: a pending memory op must not start and wbBuffer holds.
    en = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_en0_stall: got %0b expected 0", stall);
    end
    step();
    exBuffer = randOp(0);
    step();
    checks++;
    if (memReq !== 1'b0 || wbBuffer !== modelWb) begin
      errors++;
      $display("[TB] FAIL idle_en0_hold: got req=%0b wb=%h expected req=0 wb=%h", memReq, wbBuffer, modelWb);
    end
    en = 1'b1;
    runPassOp('0, "idle_en0_bubble");
  endtask

  task automatic test_timeout();
    logic [BW-1:0] op;
    op = randOp(1);
    exBuffer = op;
    memReady = 1'b0;
    step();
    for (int i = 0; i < TO - 1; i++) begin
      checks++;
      if (stall !== 1'b1 || memErr !== 1'b0 || memReq !== 1'b1) begin
        errors++;
        $display("[TB] FAIL timeout_wait%0d: got stall=%0b err=%0b req=%0b expected 1 0 1", i, stall, memErr, memReq);
      end
      step();
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_release: got stall=%0b expected 0", stall);
    end
    step();
    modelWb = wbOf(op, '0);
    checks++;
    if (memErr !== 1'b1 || memReq !== 1'b0 || wbBuffer !== modelWb) begin
      errors++;
      $display("[TB] FAIL timeout_abort: got err=%0b req=%0b wb=%h expected err=1 req=0 wb=%h", memErr, memReq, wbBuffer, modelWb);
    end
    runMemOp(randOp(1), 1, N'($urandom), "after_timeout");
    checks++;
    if (memErr !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_sticky: got %0b expected 1", memErr);
    end
    runPassOp('0, "timeout_bubble");
  endtask

  task automatic test_reset_midwait();
    exBuffer = randOp(1);
    step();
    checks++;
    if (memReq !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midwait_req: got %0b expected 1", memReq);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (memReq !== 1'b0 || stall !== 1'b0 || wbBuffer !== '0 || memErr !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midwait_async: got req=%0b stall=%0b wb=%h err=%0b expected all 0", memReq, stall, wbBuffer, memErr);
    end
    step();
    exBuffer = '0;
    rst = 1'b1;
    modelWb = '0;
    step();
    runMemOp(randOp(1), 2, N'($urandom), "post_reset");
    runPassOp('0, "post_reset_bubble");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_passthrough();
    test_load_wait3();
    test_store_ready();
    test_back_to_back();
    test_en_done();
    test_timeout();
    test_reset_midwait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
